// File: rtl/mips_mem_arb_pkg.sv
// rtl/mips_mem_arb_pkg.sv - shared types and widths for the harvard memory arbiter
package mips_mem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FETCH,
        DATA,
        COMMIT,
        HALT
    } state_t;

endpackage

// File: rtl/mips_mem_arb_watchdog.sv
// rtl/mips_mem_arb_watchdog.sv - consecutive waitrequest counter with expiry flag
module mips_mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Expiry is flagged on the wait cycle that would bring the count to TIMEOUT.
    assign expired = inc && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_cpu_harvard_mem_arbiter.sv
// rtl/mips_cpu_harvard_mem_arbiter.sv - sequences fetch, data access and commit of a harvard CPU onto one shared bus
import mips_mem_arb_pkg::*;

module mips_cpu_harvard_mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    output logic              clk_enable,
    input  logic [WORD_W-1:0] instr_address,
    output logic [WORD_W-1:0] instr_readdata,
    input  logic [WORD_W-1:0] data_address,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [WORD_W-1:0] data_writedata,
    output logic [WORD_W-1:0] data_readdata,
    output logic [WORD_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_writedata,
    input  logic [WORD_W-1:0] mem_readdata,
    input  logic              mem_waitrequest,
    output logic              error,
    output logic [WORD_W-1:0] instr_count
);

    state_t            state;
    logic              run;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              fetch_go;
    logic              load_go;
    logic              store_go;
    logic              busy;
    logic              stalled;
    logic              expired;

    // Strobes decode from registered state; run keeps the bus quiet for the first cycle after reset.
    always_comb begin
        fetch_go      = run && (state == FETCH);
        store_go      = (state == DATA) && data_write;
        load_go       = (state == DATA) && data_read && !data_write;
        busy          = fetch_go || load_go || store_go;
        stalled       = busy && mem_waitrequest;
        mem_read      = fetch_go || load_go;
        mem_write     = store_go;
        mem_address   = busy ? (fetch_go ? instr_address : data_address) : addr_q;
        mem_writedata = store_go ? data_writedata : wdata_q;
        clk_enable    = (state == COMMIT);
    end

    mips_mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!stalled),
        .inc    (stalled),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= FETCH;
            run            <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            instr_readdata <= '0;
            data_readdata  <= '0;
            error          <= 1'b0;
            instr_count    <= '0;
        end else begin
            run     <= 1'b1;
            addr_q  <= mem_address;
            wdata_q <= mem_writedata;
            if (expired) begin
                error <= 1'b1;
                state <= HALT;
            end else begin
                case (state)
                    FETCH: begin
                        if (fetch_go && !mem_waitrequest) begin
                            instr_readdata <= mem_readdata;
                            state          <= DATA;
                        end
                    end
                    DATA: begin
                        if (data_read && data_write) begin
                            error <= 1'b1;
                        end
                        if (!busy) begin
                            state <= COMMIT;
                        end else if (!mem_waitrequest) begin
                            if (load_go) begin
                                data_readdata <= mem_readdata;
                            end
                            state <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        instr_count <= instr_count + 1'b1;
                        state       <= active ? FETCH : HALT;
                    end
                    default: begin
                        state <= HALT;
                    end
                endcase
            end
        end
    end

endmodule
